// File: rtl/imem_responder.sv
// Instruction-memory responder: single outstanding fetch, fixed-latency valid/ready response, side-band preload port.
// Define IMEM_ERR_EN to flag misaligned/out-of-range fetches with resp_err and a NOP instead of wrapping.
//
//   state  | meaning
//   S_IDLE | ready for a fetch request
//   S_WAIT | latency countdown; memory is read when the counter reaches 0
//   S_RESP | response held until resp_ready
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic              resp_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              busy
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_index;
  logic              r_err_pend;
  logic              r_resp_valid;
  logic [31:0]       r_resp_inst;
  logic              r_resp_err;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_index;
  logic              w_err;

`ifdef IMEM_ERR_EN
  logic [31:0] w_offset;
  assign w_offset = req_addr - BASE_ADDR;
  assign w_index  = w_offset[ADDR_W+1:2];
  // Out of range is judged on the unwrapped offset, so any bit above the array span flags it.
  assign w_err    = (req_addr[1:0] != 2'b00) || (w_offset[31:ADDR_W+2] != '0);
`else
  assign w_index  = ADDR_W'((req_addr - BASE_ADDR) >> 2);
  assign w_err    = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_inst  = r_resp_inst;
  assign resp_err   = r_resp_err;

  // Preload port has no reset so program images survive a core reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= 4'd0;
      r_index      <= '0;
      r_err_pend   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_inst  <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_index    <= w_index;
            r_err_pend <= w_err;
            r_count    <= 4'(LATENCY - 1);
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_count == 4'd0) begin
            r_resp_valid <= 1'b1;
            if (r_err_pend) begin
              r_resp_inst <= NOP;
              r_resp_err  <= 1'b1;
            end else begin
              r_resp_inst <= r_mem[r_index];
              r_resp_err  <= 1'b0;
            end
            r_state <= S_RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver queues expected responses, a negedge monitor checks them.
// Expectations follow IMEM_ERR_EN when the bench is built with that macro.
module tb_imem_responder;

  localparam int          DEPTH     = 1024;
  localparam int          ADDR_W    = 10;
  localparam int          LATENCY   = 2;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic              resp_err;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = 32'd0;
  exp_t        exp_q[$];
  exp_t        e_mon;
  logic        prev_v = 1'b0;

  imem_responder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 32'd1;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compares every cycle the response is presented, pops on handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=%h required=no_response", resp_inst);
        end else begin
          e_mon = exp_q[0];
          if (!prev_v) chk("latency", cyc - e_mon.acc, 32'(LATENCY));
          chk("resp_inst", resp_inst, e_mon.inst);
          chk("resp_err", 32'(resp_err), 32'(e_mon.err));
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
    load_we   = 1'b1;
    load_addr = idx;
    load_data = data;
    @(negedge clk);
    load_we   = 1'b0;
  endtask

  // wr_at > 0 writes widx/wdata on the wr_at-th edge after the accept edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] einst, input logic eerr,
                       input int wr_at, input logic [ADDR_W-1:0] widx, input logic [31:0] wdata);
    exp_t e;
    int   n;
    req_addr  = addr;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.inst = einst;
    e.err  = eerr;
    e.acc  = cyc + 32'd1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (wr_at > 0) begin
      repeat (wr_at - 1) @(negedge clk);
      load_we   = 1'b1;
      load_addr = widx;
      load_data = wdata;
      @(negedge clk);
      load_we   = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    exp_t e;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    resp_ready = 1'b1;
    load_we    = 1'b0;
    load_addr  = '0;
    load_data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_inst", resp_inst, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    preload(10'd0, 32'h0010_0093);
    preload(10'd1, 32'h0020_8113);
    preload(10'd5, 32'hAAAA_AAAA);
    preload(10'd1023, 32'hDEAD_BEEF);

    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 0, '0, 32'h0);
    fetch(32'h8000_0004, 32'h0020_8113, 1'b0, 0, '0, 32'h0);

    // Backpressure: response must hold for 5 cycles with resp_ready low.
    resp_ready = 1'b0;
    req_addr   = 32'h8000_0000;
    req_valid  = 1'b1;
    e.inst = 32'h0010_0093;
    e.err  = 1'b0;
    e.acc  = cyc + 32'd1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_after_valid", 32'(resp_valid), 32'd0);
    chk("bp_after_req_ready", 32'(req_ready), 32'd1);
    chk("bp_after_busy", 32'(busy), 32'd0);
    chk("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

`ifdef IMEM_ERR_EN
    fetch(32'h8000_0002, 32'h0000_0013, 1'b1, 0, '0, 32'h0);
    fetch(32'h8000_1000, 32'h0000_0013, 1'b1, 0, '0, 32'h0);
    fetch(32'h7FFF_FFFC, 32'h0000_0013, 1'b1, 0, '0, 32'h0);
    fetch(32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0, 0, '0, 32'h0);
    fetch(32'h8000_0004, 32'h0020_8113, 1'b0, 0, '0, 32'h0);
`else
    fetch(32'h8000_1000, 32'h0010_0093, 1'b0, 0, '0, 32'h0);
    fetch(32'h8000_0006, 32'h0020_8113, 1'b0, 0, '0, 32'h0);
    fetch(32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b0, 0, '0, 32'h0);
`endif

    // Write landing one edge after accept is seen; write on the read edge is not.
    fetch(32'h8000_0014, 32'hBBBB_BBBB, 1'b0, 1, 10'd5, 32'hBBBB_BBBB);
    preload(10'd5, 32'hAAAA_AAAA);
    fetch(32'h8000_0014, 32'hAAAA_AAAA, 1'b0, 2, 10'd5, 32'hBBBB_BBBB);
    fetch(32'h8000_0014, 32'hBBBB_BBBB, 1'b0, 0, '0, 32'h0);

    // Reset while in WAIT drops the response but keeps memory.
    req_addr  = 32'h8000_0000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_req_ready_in_rst", 32'(req_ready), 32'd0);
    chk("rw_resp_valid_in_rst", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_req_ready_after", 32'(req_ready), 32'd1);
    chk("rw_busy_after", 32'(busy), 32'd0);
    repeat (4) begin
      chk("rw_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 0, '0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
